// File: rtl/auto_step_counter.sv
// auto_step_counter: a free-running tick divider that drives a saturating or
// wrapping up/down counter with a fixed step between 0 and LIMIT.
module auto_step_counter #(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned TICK_HZ  = 1,
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned STEP     = 10,
   parameter int unsigned LIMIT    = 150
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             dir,
   input  logic             wrap,
   input  logic             clear,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             at_end,
   output logic             done
);

   localparam int unsigned DIV      = (TICK_HZ == 0) ? 0 : CLK_FREQ / TICK_HZ;
   localparam int unsigned DIV_W    = (DIV < 2) ? 1 : $clog2(DIV);
   localparam int unsigned AW       = WIDTH + 1;
   localparam logic [AW-1:0]    LIMIT_A  = AW'(LIMIT);
   localparam logic [AW-1:0]    STEP_A   = AW'(STEP);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   // Reject illegal parameter sets at elaboration.
   if (STEP < 1 || STEP > LIMIT) begin : g_bad_step
      $error("auto_step_counter: STEP must satisfy 1 <= STEP <= LIMIT");
   end
   if (64'(LIMIT) > ((64'(1) << WIDTH) - 64'(1))) begin : g_bad_limit
      $error("auto_step_counter: LIMIT does not fit in WIDTH bits");
   end
   if (TICK_HZ == 0 || DIV < 2) begin : g_bad_div
      $error("auto_step_counter: CLK_FREQ/TICK_HZ must be at least 2");
   end

   logic [DIV_W-1:0] div_q, div_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tick_q, tick_d;
   logic             done_q, done_d;

   logic [AW-1:0] cur;
   logic [AW-1:0] sum;
   logic [AW-1:0] nxt;
   logic [AW-1:0] endpoint;
   logic          update;

   // Next-state: divider, step arithmetic in WIDTH+1 bits, then clear override.
   always_comb begin
      div_d    = div_q;
      count_d  = count_q;
      tick_d   = 1'b0;
      done_d   = 1'b0;
      cur      = (AW'(count_q) > LIMIT_A) ? LIMIT_A : AW'(count_q);
      sum      = cur + STEP_A;
      nxt      = cur;
      endpoint = dir ? '0 : LIMIT_A;
      update   = tick_q & run;

      if (div_q == DIV_LAST) begin
         div_d = '0;
      end else begin
         div_d = div_q + DIV_W'(1);
      end
      tick_d = (div_d == DIV_LAST);

      if (!dir) begin
         if (cur == LIMIT_A) begin
            nxt = wrap ? '0 : LIMIT_A;
         end else if (sum >= LIMIT_A) begin
            nxt = LIMIT_A;
         end else begin
            nxt = sum;
         end
      end else begin
         if (cur == '0) begin
            nxt = wrap ? LIMIT_A : '0;
         end else if (cur <= STEP_A) begin
            nxt = '0;
         end else begin
            nxt = cur - STEP_A;
         end
      end

      if (update) begin
         count_d = WIDTH'(nxt);
         done_d  = (nxt == endpoint) && (cur != endpoint);
      end

      if (clear) begin
         count_d = dir ? WIDTH'(LIMIT) : '0;
         div_d   = '0;
         tick_d  = 1'b0;
         done_d  = 1'b0;
      end
   end

   // State registers with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q   <= '0;
         count_q <= '0;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         div_q   <= div_d;
         count_q <= count_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
      end
   end

   assign count  = count_q;
   assign tick   = tick_q;
   assign done   = done_q;
   assign at_end = dir ? (count_q == '0) : (count_q == WIDTH'(LIMIT));

endmodule

// File: tb/tb_auto_step_counter.sv
// Bench for auto_step_counter: expected post-update states are queued as
// stimulus is applied and popped by a monitor after each effective tick.
module tb_auto_step_counter;

   typedef struct {
      logic [7:0] cnt;
      logic       done;
      logic       at_end;
   } exp_t;

   exp_t sb[$];

   bit   clk = 1'b0;
   logic reset = 1'b1;
   logic run   = 1'b0;
   logic dir   = 1'b0;
   logic wrap  = 1'b0;
   logic clear = 1'b0;

   logic [7:0] count_a, count_b;
   logic       tick_a, tick_b, at_end_a, at_end_b, done_a, done_b;

   logic [7:0] m_count;
   logic       m_tick, m_at_end, m_done;

   bit sel      = 1'b0;
   bit mon_en   = 1'b0;
   bit prev_upd = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   auto_step_counter #(
      .CLK_FREQ(10), .TICK_HZ(1), .WIDTH(8), .STEP(10), .LIMIT(150)
   ) u_dut (
      .clk(clk), .reset(reset), .run(run), .dir(dir), .wrap(wrap), .clear(clear),
      .count(count_a), .tick(tick_a), .at_end(at_end_a), .done(done_a)
   );

   auto_step_counter #(
      .CLK_FREQ(10), .TICK_HZ(1), .WIDTH(8), .STEP(40), .LIMIT(150)
   ) u_dut40 (
      .clk(clk), .reset(reset), .run(run), .dir(dir), .wrap(wrap), .clear(clear),
      .count(count_b), .tick(tick_b), .at_end(at_end_b), .done(done_b)
   );

   always #5 clk = ~clk;

   // Observe whichever instance the current phase targets.
   always_comb begin
      m_count  = sel ? count_b  : count_a;
      m_tick   = sel ? tick_b   : tick_a;
      m_at_end = sel ? at_end_b : at_end_a;
      m_done   = sel ? done_b   : done_a;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic push(input logic [7:0] c, input logic d, input logic a);
      exp_t e;
      e.cnt    = c;
      e.done   = d;
      e.at_end = a;
      sb.push_back(e);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (sb.size() != 0) begin
         check("drain_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (m_tick !== 1'b1 && n < 40);
   endtask

   // Monitor: the cycle after an effective tick must match the queue head.
   always @(negedge clk) begin : mon
      exp_t e;
      if (mon_en) begin
         if (prev_upd) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
               e = sb.pop_front();
               check("count",  32'(m_count),  32'(e.cnt));
               check("done",   32'(m_done),   32'(e.done));
               check("at_end", 32'(m_at_end), 32'(e.at_end));
            end
         end else begin
            check("done_idle", 32'(m_done), 32'd0);
         end
      end
      prev_upd = (m_tick === 1'b1) && (run === 1'b1) && (clear !== 1'b1) && (reset !== 1'b1);
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int n;
      int ticks;

      // Reset state
      reset = 1'b1; run = 1'b1; dir = 1'b0; wrap = 1'b1; clear = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_count",  32'(m_count),  32'd0);
      check("rst_tick",   32'(m_tick),   32'd0);
      check("rst_done",   32'(m_done),   32'd0);
      check("rst_at_end_up", 32'(m_at_end), 32'd0);
      dir = 1'b1;
      #1;
      check("rst_at_end_dn", 32'(m_at_end), 32'd1);
      dir = 1'b0;

      // Up count with wrap
      for (int i = 1; i <= 15; i++) begin
         push(8'(10 * i), (i == 15), (i == 15));
      end
      push(8'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;
      wait_tick(n);
      check("first_tick_after_reset", 32'(n), 32'd10);
      drain();

      // Up count with hold at the endpoint
      wrap = 1'b0;
      for (int i = 1; i <= 14; i++) begin
         push(8'(10 * i), 1'b0, 1'b0);
      end
      push(8'd150, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         push(8'd150, 1'b0, 1'b1);
      end
      drain();

      // Pause at 60
      @(posedge clk);
      #1;
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      check("clear_up_count", 32'(m_count), 32'd0);
      for (int i = 1; i <= 6; i++) begin
         push(8'(10 * i), 1'b0, 1'b0);
      end
      drain();
      run   = 1'b0;
      ticks = 0;
      repeat (35) begin
         @(negedge clk);
         if (m_tick === 1'b1) ticks++;
      end
      check("pause_count", 32'(m_count), 32'd60);
      check("pause_ticks", 32'(ticks), 32'd3);
      push(8'd70, 1'b0, 1'b0);
      run = 1'b1;
      drain();

      // Clear coincident with a tick at 80
      push(8'd80, 1'b0, 1'b0);
      drain();
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (m_tick !== 1'b1 && n < 20);
      check("tick_before_clear", 32'(m_tick), 32'd1);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      check("clear_tick_count", 32'(m_count), 32'd0);
      check("clear_tick_done",  32'(m_done),  32'd0);
      check("clear_tick_tick",  32'(m_tick),  32'd0);
      push(8'd10, 1'b0, 1'b0);
      wait_tick(n);
      check("tick_after_clear", 32'(n), 32'd10);
      drain();

      // Reset the cycle before a tick at 140
      for (int i = 2; i <= 14; i++) begin
         push(8'(10 * i), 1'b0, 1'b0);
      end
      drain();
      repeat (8) @(posedge clk);
      #1;
      check("pre_reset_tick", 32'(m_tick), 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("mid_reset_count", 32'(m_count), 32'd0);
      check("mid_reset_done",  32'(m_done),  32'd0);
      check("mid_reset_tick",  32'(m_tick),  32'd0);
      push(8'd10, 1'b0, 1'b0);
      wait_tick(n);
      check("tick_after_reset", 32'(n), 32'd10);
      drain();

      // Down count with clamp on the STEP=40 instance
      @(posedge clk);
      #1;
      sel   = 1'b1;
      dir   = 1'b1;
      wrap  = 1'b0;
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      check("clear_dn_count",  32'(m_count),  32'd150);
      check("clear_dn_at_end", 32'(m_at_end), 32'd0);
      check("clear_dn_done",   32'(m_done),   32'd0);
      push(8'd110, 1'b0, 1'b0);
      push(8'd70,  1'b0, 1'b0);
      push(8'd30,  1'b0, 1'b0);
      push(8'd0,   1'b1, 1'b1);
      drain();
      wrap = 1'b1;
      push(8'd150, 1'b0, 1'b0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
